wb_burst_master: RTL and testbench

- Wishbone classic initiator, the counterpart of the user-area Wishbone slave port.
- Turns a simple command/write-data/response stream interface into single or incrementing-burst Wishbone cycles.
- Used to exercise the slave-side SRAM controller from an on-chip sequencer or logic-analyzer bridge.
- Provides per-beat responses and a bus timeout so a hung slave cannot stall the sequencer.

---
 rtl/wb_burst_master.sv | 180 ++++++++++++++++++
 tb/tb_wb_burst_master.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone classic initiator. It turns a command / write-data / response
// stream interface into single or incrementing-burst Wishbone cycles. Each beat returns one
// response. A bus timeout aborts the burst so that a hung slave cannot stall the sequencer.
//
// Ports
//   wb_clk_i, wb_rst_ni        clock, asynchronous active-low reset
//   cmd_*                      command stream (we, byte address, sel, beats-1)
//   wdat_*                     write-data stream, one word per write beat
//   rsp_*                      response stream (data, err, last), one per beat
//   wbm_*                      Wishbone classic master port
//   busy_o                     high whenever a command is in progress
module wb_burst_master #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned LENW    = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [AW-1:0]     cmd_adr_i,
  input  logic [DW/8-1:0]   cmd_sel_i,
  input  logic [LENW-1:0]   cmd_len_i,
  input  logic              wdat_valid_i,
  output logic              wdat_ready_o,
  input  logic [DW-1:0]     wdat_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DW-1:0]     rsp_dat_o,
  output logic              rsp_err_o,
  output logic              rsp_last_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [DW/8-1:0]   wbm_sel_o,
  output logic [AW-1:0]     wbm_adr_o,
  output logic [DW-1:0]     wbm_dat_o,
  input  logic [DW-1:0]     wbm_dat_i,
  input  logic              wbm_ack_i,
  output logic              busy_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value in the final stb cycle before the timeout fires.
  localparam logic [TW-1:0] TmoLast = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWdat,
    StReq,
    StRsp
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [LENW-1:0]   beats_left_q, beats_left_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [DW-1:0]     rsp_dat_q, rsp_dat_d;
  logic              rsp_err_q, rsp_err_d;
  logic              abort_q, abort_d;
  logic              cyc_q, cyc_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic              last_beat;

  assign last_beat = (beats_left_q == '0) || abort_q;

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    adr_d        = adr_q;
    sel_d        = sel_q;
    beats_left_d = beats_left_q;
    dat_d        = dat_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_err_d    = rsp_err_q;
    abort_d      = abort_q;
    cyc_d        = cyc_q;
    tmo_cnt_d    = tmo_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          we_d         = cmd_we_i;
          adr_d        = cmd_adr_i & ~AW'(3);
          sel_d        = cmd_sel_i;
          beats_left_d = cmd_len_i;
          tmo_cnt_d    = '0;
          abort_d      = 1'b0;
          // Reads open the cycle right away; writes wait until the first data word.
          cyc_d        = ~cmd_we_i;
          state_d      = cmd_we_i ? StWdat : StReq;
        end
      end
      StWdat: begin
        if (wdat_valid_i) begin
          dat_d   = wdat_i;
          cyc_d   = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (wbm_ack_i) begin
          rsp_dat_d = we_q ? '0 : wbm_dat_i;
          rsp_err_d = 1'b0;
          state_d   = StRsp;
        end else if ((TIMEOUT != 0) && (tmo_cnt_q == TmoLast)) begin
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          abort_d   = 1'b1;
          cyc_d     = 1'b0;
          state_d   = StRsp;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StRsp: begin
        if (rsp_ready_i) begin
          if (last_beat) begin
            cyc_d   = 1'b0;
            state_d = StIdle;
          end else begin
            adr_d        = adr_q + AW'(4);
            beats_left_d = beats_left_q - 1'b1;
            tmo_cnt_d    = '0;
            state_d      = we_q ? StWdat : StReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      adr_q        <= '0;
      sel_q        <= '0;
      beats_left_q <= '0;
      dat_q        <= '0;
      rsp_dat_q    <= '0;
      rsp_err_q    <= 1'b0;
      abort_q      <= 1'b0;
      cyc_q        <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      sel_q        <= sel_d;
      beats_left_q <= beats_left_d;
      dat_q        <= dat_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_err_q    <= rsp_err_d;
      abort_q      <= abort_d;
      cyc_q        <= cyc_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign cmd_ready_o  = (state_q == StIdle);
  assign wdat_ready_o = (state_q == StWdat);
  assign rsp_valid_o  = (state_q == StRsp);
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_err_o    = rsp_err_q;
  assign rsp_last_o   = (state_q == StRsp) && last_beat;
  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = (state_q == StReq);
  assign wbm_we_o     = we_q;
  assign wbm_sel_o    = sel_q;
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = dat_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_wb_burst_master.sv
module tb_wb_burst_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [3:0]  cmd_sel = '0;
  logic [3:0]  cmd_len = '0;
  logic        wdat_valid = 1'b0;
  logic        wdat_ready;
  logic [31:0] wdat = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_last;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i = '0;
  logic        ack = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_burst_master #(
    .AW(32), .DW(32), .LENW(4), .TIMEOUT(8)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_sel_i   (cmd_sel),
    .cmd_len_i   (cmd_len),
    .wdat_valid_i(wdat_valid),
    .wdat_ready_o(wdat_ready),
    .wdat_i      (wdat),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .rsp_last_o  (rsp_last),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_sel_o   (sel),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (dat_o),
    .wbm_dat_i   (dat_i),
    .wbm_ack_i   (ack),
    .busy_o      (busy)
  );

  // Presents a command for one cycle; the caller is in IDLE so it is accepted at the next edge.
  task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [3:0] l);
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_sel = s; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({cmd_ready, wdat_ready, rsp_valid, rsp_err, rsp_last, cyc, stb, we, busy} !==
        9'b1_0000_0000 || rsp_dat !== 0 || adr !== 0 || sel !== 0 || dat_o !== 0) begin
      errors++;
      $display("FAIL reset_outputs: ctl=%b adr=%h sel=%h dat=%h rdat=%h, required ctl=100000000, rest 0",
               {cmd_ready, wdat_ready, rsp_valid, rsp_err, rsp_last, cyc, stb, we, busy},
               adr, sel, dat_o, rsp_dat);
    end
  endtask

  task automatic test_single_read();
    issue_cmd(1'b0, 32'h3000_0013, 4'hF, 4'd0);
    checks++;
    if (!(stb && cyc && !we && adr == 32'h3000_0010 && sel == 4'hF)) begin
      errors++;
      $display("FAIL single_req: stb=%b cyc=%b we=%b adr=%h sel=%h, required 1 1 0 30000010 f",
               stb, cyc, we, adr, sel);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (stb !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_wait: stb=%b rsp_valid=%b, required 1 0", stb, rsp_valid);
    end
    ack = 1'b1; dat_i = 32'hDEAD_BEEF;
    @(negedge clk);
    ack = 1'b0; dat_i = '0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_last, stb, cyc} !== 5'b10101 || rsp_dat !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_rsp: v/e/l/stb/cyc=%b dat=%h, required 10101 deadbeef",
               {rsp_valid, rsp_err, rsp_last, stb, cyc}, rsp_dat);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({cyc, rsp_valid, cmd_ready, busy} !== 4'b0010) begin
      errors++;
      $display("FAIL single_end: cyc/v/ready/busy=%b, required 0010", {cyc, rsp_valid, cmd_ready, busy});
    end
  endtask

  // Incrementing read burst with immediate acks; optionally stalls beat 2's response.
  task automatic test_read_burst(input logic [31:0] base, input logic [3:0] len,
                                 input bit stall, input string name);
    logic [31:0] exp_adr;
    issue_cmd(1'b0, base, 4'hF, len);
    for (int b = 0; b <= int'(len); b++) begin
      exp_adr = base + 32'(4 * b);
      checks++;
      if (!(stb && cyc) || adr !== exp_adr) begin
        errors++;
        $display("FAIL %s_adr%0d: stb=%b cyc=%b adr=%h, required 1 1 %h", name, b, stb, cyc,
                 adr, exp_adr);
      end
      ack = 1'b1; dat_i = 32'h0000_1000 + 32'(b);
      @(negedge clk);
      ack = 1'b0; dat_i = 32'hBAD0_BAD0;
      checks++;
      if (!rsp_valid || rsp_dat !== 32'h0000_1000 + 32'(b) || rsp_err ||
          rsp_last !== (b == int'(len)) || !cyc || stb) begin
        errors++;
        $display("FAIL %s_rsp%0d: v=%b dat=%h err=%b last=%b cyc=%b stb=%b, required 1 %h 0 %b 1 0",
                 name, b, rsp_valid, rsp_dat, rsp_err, rsp_last, cyc, stb,
                 32'h0000_1000 + 32'(b), b == int'(len));
      end
      if (stall && b == 1) begin
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          checks++;
          if (!rsp_valid || rsp_dat !== 32'h0000_1001 || rsp_last || !cyc || stb) begin
            errors++;
            $display("FAIL %s_stall%0d: v=%b dat=%h last=%b cyc=%b stb=%b, required 1 00001001 0 1 0",
                     name, s, rsp_valid, rsp_dat, rsp_last, cyc, stb);
          end
        end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    checks++;
    if (cyc || stb || !cmd_ready) begin
      errors++;
      $display("FAIL %s_end: cyc=%b stb=%b cmd_ready=%b, required 0 0 1", name, cyc, stb, cmd_ready);
    end
  endtask

  task automatic test_write_burst();
    logic [31:0] wv [3];
    wv[0] = 32'hA5A5_0001; wv[1] = 32'h5A5A_0002; wv[2] = 32'hC3C3_0003;
    issue_cmd(1'b1, 32'h3000_0100, 4'hF, 4'd2);
    checks++;
    if ({wdat_ready, stb, cyc, cmd_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL wr_first_wdat: wrdy/stb/cyc/crdy=%b, required 1000", {wdat_ready, stb, cyc, cmd_ready});
    end
    for (int b = 0; b < 3; b++) begin
      if (b == 1) begin
        for (int g = 0; g < 5; g++) begin
          checks++;
          if ({wdat_ready, stb, cyc} !== 3'b101) begin
            errors++;
            $display("FAIL wr_gap%0d: wrdy/stb/cyc=%b, required 101", g, {wdat_ready, stb, cyc});
          end
          @(negedge clk);
        end
      end
      wdat_valid = 1'b1; wdat = wv[b];
      @(negedge clk);
      wdat_valid = 1'b0; wdat = '0;
      checks++;
      if (!(stb && cyc && we) || dat_o !== wv[b] || adr !== 32'h3000_0100 + 32'(4 * b) ||
          sel !== 4'hF) begin
        errors++;
        $display("FAIL wr_req%0d: stb=%b cyc=%b we=%b dat=%h adr=%h sel=%h, required 1 1 1 %h %h f",
                 b, stb, cyc, we, dat_o, adr, sel, wv[b], 32'h3000_0100 + 32'(4 * b));
      end
      ack = 1'b1; dat_i = 32'hFFFF_FFFF;
      @(negedge clk);
      ack = 1'b0; dat_i = '0;
      checks++;
      if (!rsp_valid || rsp_dat !== 0 || rsp_err || rsp_last !== (b == 2)) begin
        errors++;
        $display("FAIL wr_rsp%0d: v=%b dat=%h err=%b last=%b, required 1 0 0 %b", b, rsp_valid,
                 rsp_dat, rsp_err, rsp_last, b == 2);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    checks++;
    if (cyc || busy) begin
      errors++;
      $display("FAIL wr_end: cyc=%b busy=%b, required 0 0", cyc, busy);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    issue_cmd(1'b0, 32'h3000_0200, 4'hF, 4'd3);
    while (stb && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL tmo_stb_cycles: got %0d, required 8", n);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_last, cyc, stb} !== 5'b11100 || rsp_dat !== 0) begin
      errors++;
      $display("FAIL tmo_rsp: v/e/l/cyc/stb=%b dat=%h, required 11100 0",
               {rsp_valid, rsp_err, rsp_last, cyc, stb}, rsp_dat);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({stb, cyc, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL tmo_idle%0d: stb/cyc/v/busy/crdy=%b, required 00001", i,
                 {stb, cyc, rsp_valid, busy, cmd_ready});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_burst();
    issue_cmd(1'b0, 32'h3000_0300, 4'hF, 4'd3);
    checks++;
    if (!stb) begin
      errors++;
      $display("FAIL rst_pre: stb=%b, required 1", stb);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cyc, stb, rsp_valid, cmd_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL rst_async: cyc/stb/v/crdy=%b, required 0001", {cyc, stb, rsp_valid, cmd_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (!cmd_ready || busy) begin
      errors++;
      $display("FAIL rst_release: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
    issue_cmd(1'b0, 32'h3000_0040, 4'h3, 4'd0);
    checks++;
    if (!stb || adr !== 32'h3000_0040 || sel !== 4'h3) begin
      errors++;
      $display("FAIL rst_new_req: stb=%b adr=%h sel=%h, required 1 30000040 3", stb, adr, sel);
    end
    ack = 1'b1; dat_i = 32'h1234_5678;
    @(negedge clk);
    ack = 1'b0; dat_i = '0;
    checks++;
    if (!rsp_valid || !rsp_last || rsp_err || rsp_dat !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rst_new_rsp: v=%b l=%b e=%b dat=%h, required 1 1 0 12345678", rsp_valid,
               rsp_last, rsp_err, rsp_dat);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (cyc || !cmd_ready) begin
      errors++;
      $display("FAIL rst_new_end: cyc=%b cmd_ready=%b, required 0 1", cyc, cmd_ready);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_read_burst(32'h3000_0000, 4'd3, 1'b1, "rd4");
    test_write_burst();
    test_timeout();
    test_read_burst(32'hFFFF_FFF8, 4'd2, 1'b0, "wrap");
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
